// File: rtl/id_issue_if.sv
// id_issue_if: fetch, writeback and ID/EX signals between issue stage and its neighbours
interface id_issue_if;
  logic        if_valid;
  logic [15:0] if_instr;
  logic        if_ready;
  logic        flush;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic        ex_ready;
  logic        ID_EX_valid;
  logic [4:0]  ID_EX_opcode;
  logic        ID_EX_addressing_mode;
  logic [2:0]  ID_EX_rd;
  logic [2:0]  ID_EX_rs1;
  logic [2:0]  ID_EX_rs2;
  logic [3:0]  ID_EX_data_mem;
  logic [5:0]  ID_EX_instruction_mem;
  logic [2:0]  ID_EX_s_r_amount;
  logic        stall;
  modport master (
    output if_valid, if_instr, flush, wb_valid, wb_rd, ex_ready,
    input  if_ready, ID_EX_valid, ID_EX_opcode, ID_EX_addressing_mode, ID_EX_rd, ID_EX_rs1,
           ID_EX_rs2, ID_EX_data_mem, ID_EX_instruction_mem, ID_EX_s_r_amount, stall
  );
  modport slave (
    input  if_valid, if_instr, flush, wb_valid, wb_rd, ex_ready,
    output if_ready, ID_EX_valid, ID_EX_opcode, ID_EX_addressing_mode, ID_EX_rd, ID_EX_rs1,
           ID_EX_rs2, ID_EX_data_mem, ID_EX_instruction_mem, ID_EX_s_r_amount, stall
  );
endinterface

// File: rtl/id_issue_stage.sv
// id_issue_stage: IF/ID holding register, decode, scoreboard hazard stall and ID/EX issue
module id_issue_stage (
  input logic clk,
  input logic rst,
  id_issue_if.slave bus
);
  logic        ifid_valid;
  logic [15:0] ifid_instr;
  logic [7:0]  busy, pend, set_mask, clr_mask;
  logic [4:0]  op;
  logic        nop, jump, wr, rd1, rd2, ex_wr, hazard, issue, handoff;
  // decode the held word, build the pending-write view and the issue/handoff terms
  always_comb begin
    op = ifid_instr[15:11];
    nop = op == 5'd0;
    jump = op[4:3] == 2'b11;
    wr = !nop && !jump;
    rd1 = !nop;
    rd2 = wr && !ifid_instr[10];
    ex_wr = bus.ID_EX_opcode != 5'd0 && bus.ID_EX_opcode[4:3] != 2'b11;
    pend = busy | ((bus.ID_EX_valid && ex_wr) ? (8'd1 << bus.ID_EX_rd) : 8'd0);
    hazard = ifid_valid && ((rd1 && pend[ifid_instr[6:4]]) || (rd2 && pend[ifid_instr[3:1]])
             || (wr && pend[ifid_instr[9:7]]));
    issue = ifid_valid && !hazard && !bus.flush && (!bus.ID_EX_valid || bus.ex_ready);
    handoff = bus.ID_EX_valid && bus.ex_ready && !bus.flush;
    set_mask = (handoff && ex_wr) ? (8'd1 << bus.ID_EX_rd) : 8'd0;
    clr_mask = bus.wb_valid ? (8'd1 << bus.wb_rd) : 8'd0;
  end
  assign bus.if_ready = !rst && !bus.flush && (!ifid_valid || issue);
  assign bus.stall = hazard;
  // scoreboard, IF/ID and ID/EX registers; a set beats a same-cycle writeback clear
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      bus.ID_EX_valid <= 1'b0;
      bus.ID_EX_opcode <= '0;
      bus.ID_EX_addressing_mode <= 1'b0;
      bus.ID_EX_rd <= '0;
      bus.ID_EX_rs1 <= '0;
      bus.ID_EX_rs2 <= '0;
      bus.ID_EX_data_mem <= '0;
      bus.ID_EX_instruction_mem <= '0;
      bus.ID_EX_s_r_amount <= '0;
    end else begin
      busy <= (busy & ~clr_mask) | set_mask;
      if (bus.flush) ifid_valid <= 1'b0;
      else if (bus.if_valid && bus.if_ready) begin
        ifid_valid <= 1'b1;
        ifid_instr <= bus.if_instr;
      end else if (issue) ifid_valid <= 1'b0;
      if (bus.flush) bus.ID_EX_valid <= 1'b0;
      else if (issue) begin
        bus.ID_EX_valid <= 1'b1;
        bus.ID_EX_opcode <= op;
        bus.ID_EX_addressing_mode <= ifid_instr[10];
        bus.ID_EX_rd <= ifid_instr[9:7];
        bus.ID_EX_rs1 <= ifid_instr[6:4];
        bus.ID_EX_rs2 <= ifid_instr[3:1];
        bus.ID_EX_data_mem <= ifid_instr[3:0];
        bus.ID_EX_instruction_mem <= ifid_instr[5:0];
        bus.ID_EX_s_r_amount <= ifid_instr[2:0];
      end else if (handoff) bus.ID_EX_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_id_issue_stage.sv
// tb_id_issue_stage: directed checks of decode, issue, hazard stall, backpressure and flush
module tb_id_issue_stage;
  logic clk = 1'b0;
  logic rst;
  int n_run = 0;
  int n_fail = 0;
  id_issue_if bus();
  id_issue_stage dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.if_valid = 1'b0;
    bus.flush = 1'b0;
    bus.wb_valid = 1'b0;
    bus.wb_rd = 3'd0;
    bus.ex_ready = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.if_valid = 1'b1;
    bus.if_instr = 16'h0890;
    bus.flush = 1'b0;
    bus.wb_valid = 1'b0;
    bus.wb_rd = 3'd0;
    bus.ex_ready = 1'b1;
    tick();
    tick();
    chk("rst_if_ready", 32'(bus.if_ready), 0);
    chk("rst_valid", 32'(bus.ID_EX_valid), 0);
    chk("rst_opcode", 32'(bus.ID_EX_opcode), 0);
    chk("rst_rd", 32'(bus.ID_EX_rd), 0);
    chk("rst_imem", 32'(bus.ID_EX_instruction_mem), 0);
    chk("rst_stall", 32'(bus.stall), 0);
    chk("rst_busy", 32'(dut.busy), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_if_ready", 32'(bus.if_ready), 1);
    tick();
    chk("lat_valid0", 32'(bus.ID_EX_valid), 0);
    chk("cap_if_ready", 32'(bus.if_ready), 1);
    bus.if_instr = 16'h0A24;
    tick();
    chk("s1_valid", 32'(bus.ID_EX_valid), 1);
    chk("s1_opcode", 32'(bus.ID_EX_opcode), 1);
    chk("s1_rd", 32'(bus.ID_EX_rd), 1);
    chk("s1_rs1", 32'(bus.ID_EX_rs1), 1);
    chk("s1_rs2", 32'(bus.ID_EX_rs2), 0);
    chk("s1_imem", 32'(bus.ID_EX_instruction_mem), 'h10);
    chk("s1_stall", 32'(bus.stall), 0);
    bus.if_instr = 16'h12BC;
    tick();
    chk("s2_valid", 32'(bus.ID_EX_valid), 1);
    chk("s2_rd", 32'(bus.ID_EX_rd), 4);
    chk("s2_rs1", 32'(bus.ID_EX_rs1), 2);
    chk("s2_rs2", 32'(bus.ID_EX_rs2), 2);
    chk("s2_dmem", 32'(bus.ID_EX_data_mem), 4);
    chk("s2_imem", 32'(bus.ID_EX_instruction_mem), 'h24);
    chk("s2_sr", 32'(bus.ID_EX_s_r_amount), 4);
    chk("s2_stall", 32'(bus.stall), 0);
    bus.if_valid = 1'b0;
    tick();
    chk("s3_valid", 32'(bus.ID_EX_valid), 1);
    chk("s3_opcode", 32'(bus.ID_EX_opcode), 2);
    chk("s3_mode", 32'(bus.ID_EX_addressing_mode), 0);
    chk("s3_rd", 32'(bus.ID_EX_rd), 5);
    chk("s3_rs1", 32'(bus.ID_EX_rs1), 3);
    chk("s3_rs2", 32'(bus.ID_EX_rs2), 6);
    chk("s3_stall", 32'(bus.stall), 0);
    tick();
    chk("s_drain_valid", 32'(bus.ID_EX_valid), 0);
    chk("s_busy", 32'(dut.busy), 'h32);

    do_reset();
    bus.if_valid = 1'b1;
    bus.if_instr = 16'h1994;
    tick();
    bus.if_instr = 16'h2730;
    tick();
    bus.if_valid = 1'b0;
    chk("raw_w_rd", 32'(bus.ID_EX_rd), 3);
    chk("raw_stall_a", 32'(bus.stall), 1);
    chk("raw_if_ready_a", 32'(bus.if_ready), 0);
    tick();
    chk("raw_stall_b", 32'(bus.stall), 1);
    chk("raw_if_ready_b", 32'(bus.if_ready), 0);
    chk("raw_valid_b", 32'(bus.ID_EX_valid), 0);
    chk("raw_busy_set", 32'(dut.busy), 'h08);
    tick();
    chk("raw_stall_c", 32'(bus.stall), 1);
    bus.wb_valid = 1'b1;
    bus.wb_rd = 3'd3;
    #1;
    chk("raw_stall_wb_cycle", 32'(bus.stall), 1);
    tick();
    bus.wb_valid = 1'b0;
    #1;
    chk("raw_stall_clear", 32'(bus.stall), 0);
    chk("raw_valid_wait", 32'(bus.ID_EX_valid), 0);
    chk("raw_if_ready", 32'(bus.if_ready), 1);
    tick();
    chk("raw_issue_valid", 32'(bus.ID_EX_valid), 1);
    chk("raw_issue_opcode", 32'(bus.ID_EX_opcode), 4);
    chk("raw_issue_rd", 32'(bus.ID_EX_rd), 6);
    chk("raw_issue_rs1", 32'(bus.ID_EX_rs1), 3);
    chk("raw_issue_mode", 32'(bus.ID_EX_addressing_mode), 1);
    chk("raw_busy_end", 32'(dut.busy), 0);

    do_reset();
    bus.ex_ready = 1'b0;
    bus.if_valid = 1'b1;
    bus.if_instr = 16'h0890;
    tick();
    bus.if_instr = 16'h12BC;
    tick();
    bus.if_instr = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_valid", 32'(bus.ID_EX_valid), 1);
      chk("bp_opcode", 32'(bus.ID_EX_opcode), 1);
      chk("bp_rd", 32'(bus.ID_EX_rd), 1);
      chk("bp_if_ready", 32'(bus.if_ready), 0);
      chk("bp_stall", 32'(bus.stall), 0);
    end
    bus.ex_ready = 1'b1;
    bus.if_valid = 1'b0;
    #1;
    chk("bp_release_if_ready", 32'(bus.if_ready), 1);
    tick();
    chk("bp_next_valid", 32'(bus.ID_EX_valid), 1);
    chk("bp_next_opcode", 32'(bus.ID_EX_opcode), 2);
    chk("bp_next_rd", 32'(bus.ID_EX_rd), 5);
    chk("bp_busy", 32'(dut.busy), 'h02);
    tick();
    chk("bp_drain_valid", 32'(bus.ID_EX_valid), 0);

    do_reset();
    bus.ex_ready = 1'b0;
    bus.if_valid = 1'b1;
    bus.if_instr = 16'h1294;
    tick();
    bus.if_instr = 16'h0890;
    tick();
    chk("fl_pre_rd", 32'(bus.ID_EX_rd), 5);
    bus.if_valid = 1'b0;
    bus.flush = 1'b1;
    bus.ex_ready = 1'b1;
    #1;
    chk("fl_if_ready", 32'(bus.if_ready), 0);
    tick();
    bus.flush = 1'b0;
    #1;
    chk("fl_valid", 32'(bus.ID_EX_valid), 0);
    chk("fl_busy", 32'(dut.busy), 0);
    chk("fl_if_ready_after", 32'(bus.if_ready), 1);
    bus.if_valid = 1'b1;
    bus.if_instr = 16'h2FD0;
    tick();
    bus.if_valid = 1'b0;
    #1;
    chk("fl_reader_stall", 32'(bus.stall), 0);
    tick();
    chk("fl_reader_valid", 32'(bus.ID_EX_valid), 1);
    chk("fl_reader_opcode", 32'(bus.ID_EX_opcode), 5);
    chk("fl_reader_rs1", 32'(bus.ID_EX_rs1), 5);
    chk("fl_reader_rd", 32'(bus.ID_EX_rd), 7);

    do_reset();
    bus.ex_ready = 1'b0;
    bus.if_valid = 1'b1;
    bus.if_instr = 16'h0D00;
    tick();
    bus.if_valid = 1'b0;
    tick();
    chk("col_valid", 32'(bus.ID_EX_valid), 1);
    bus.ex_ready = 1'b1;
    bus.wb_valid = 1'b1;
    bus.wb_rd = 3'd2;
    tick();
    chk("col_busy", 32'(dut.busy), 'h04);
    chk("col_drain", 32'(bus.ID_EX_valid), 0);
    bus.wb_rd = 3'd6;
    tick();
    bus.wb_valid = 1'b0;
    chk("wb_harmless", 32'(dut.busy), 'h04);
    rst = 1'b1;
    bus.flush = 1'b1;
    tick();
    rst = 1'b0;
    bus.flush = 1'b0;
    chk("midrst_busy", 32'(dut.busy), 0);

    bus.if_valid = 1'b1;
    bus.if_instr = 16'h0000;
    tick();
    bus.if_instr = 16'hC380;
    tick();
    chk("nop_valid", 32'(bus.ID_EX_valid), 1);
    chk("nop_opcode", 32'(bus.ID_EX_opcode), 0);
    bus.if_valid = 1'b0;
    tick();
    chk("jmp_opcode", 32'(bus.ID_EX_opcode), 'h18);
    chk("jmp_rd", 32'(bus.ID_EX_rd), 7);
    chk("nop_busy", 32'(dut.busy), 0);
    tick();
    chk("jmp_busy", 32'(dut.busy), 0);
    chk("jmp_drain", 32'(bus.ID_EX_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
